fan_pwm_controller: RTL
=======================

Name: fan_pwm_controller

Overview:
- Avalon-MM slave that drives the two printer fan outputs with per-fan PWM duty instead of plain on/off bits.
- Sits on the HPS lightweight bridge in place of a bare output port.
- Provides a shared free-running PWM timebase, glitch-free duty updates at period boundaries, and a per-fan kickstart sequence (full power for a programmable number of PWM periods on enable).

Parameters:
- PRESCALE, 50: clk cycles per PWM tick. Range 2..65535; 50 MHz clk gives a 1 MHz tick.
- KICK_DEFAULT, 100: reset value of KICK_LEN, in PWM periods.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait/latency
- fan_out  out  2  fan drive, bit i = fan i, registered

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. Write accepted when chipselect && !write_n.
- Register map, read and write unless noted:
  - addr0 CTRL: [1:0] fan enable, reset 0.
  - addr1 DUTY0: [7:0], reset 0.
  - addr2 DUTY1: [7:0], reset 0.
  - addr3 KICK: write [15:0] = KICK_LEN; read [15:0] = KICK_LEN, [17:16] = per-fan "in KICK" flags.
  - Unused readdata bits read 0.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick asserted in the cycle it equals PRESCALE-1, then wraps to 0.
  - 8-bit pwm_cnt increments on tick and wraps 255->0; period = 256 ticks.
  - "wrap" = tick while pwm_cnt==255.
  - Both counters free-run from reset and are never cleared by register writes.
- Duty shadowing:
  - Written DUTYi goes to a staging register.
  - Active duty loads from staging on wrap only, so no mid-period change.
  - Reset value of active duty = 0.
- PWM compare:
  - pwm_i = (duty_act==255) ? 1 : (pwm_cnt < duty_act).
  - duty 0 gives constant low; duty 255 gives constant high.
- Per-fan FSM, states OFF, KICK, RUN:
  - OFF: fan_out[i]=0. On CTRL[i]==1: go to KICK if KICK_LEN!=0, else RUN.
  - KICK:
    - On entry, load kick_cnt = KICK_LEN.
    - fan_out[i]=1. Decrement on each wrap.
    - Wrap with kick_cnt==1 goes to RUN.
    - Duration = partial period to first wrap + (KICK_LEN-1) full periods.
  - RUN: fan_out[i]=pwm_i.
  - KICK or RUN with CTRL[i]==0: go to OFF on the next edge.
  - Re-enable from OFF always starts a fresh kick.
- Timing:
  - Enable write in cycle N: CTRL updates at edge N+1, FSM at edge N+2.
  - fan_out changes at edge N+2 (fan_out is registered from the FSM next-state/compare).
  - Disable follows the same 2-edge latency.
- Boundary cases:
  - KICK_LEN written during KICK: the current kick is unaffected (uses the loaded count); the new value applies to the next kick.
  - Duty written to 0 in RUN: state stays RUN, output goes low from the next wrap; no re-kick when duty later becomes nonzero.
  - Enable write that does not change the bit (1->1): no effect.
  - Write and wrap in the same cycle: the staging register takes the new value; the active register loads the old staged value, and the new value applies at the following wrap.
  - reset_n assertion at any time, mid-kick or mid-period: all counters and registers, the FSMs (to OFF) and fan_out go to 0 immediately (asynchronous); KICK_LEN goes to KICK_DEFAULT.

Optional Feature:
- FAN_KICKSTART_EN defined: KICK state, kick_cnt and addr3 implemented as above.
- Undefined:
  - No KICK state; OFF goes directly to RUN on enable.
  - addr3 writes ignored, addr3 reads 0.
  - KICK_LEN and kick_cnt not synthesized.

Test Plan (bench uses PRESCALE=2; FAN_KICKSTART_EN defined except scenario 6):
- Reset asserted mid-run, released -> fan_out=2'b00; addr0/1/2 read 0; addr3 reads 0x0000_0064.
- KICK_LEN=0, DUTY0=64, CTRL=1 -> fan_out[0] high exactly 128 clk (64 ticks) per 512-clk period, rising at each wrap; fan_out[1]=0.
- KICK_LEN=3, DUTY1=32, CTRL=2:
  - fan_out[1] constant 1 and readdata[17]=1 until the 3rd wrap after entry.
  - Then 64 clk high per 512 clk; readdata[17]=0.
- DUTY0 changed 64->192 mid-period -> current period keeps 128-clk high pulse; next period 384-clk high; no extra edges.
- Disable fan1 during kick, then re-enable -> fan_out[1]=0 two edges after disable write; re-enable restarts a full 3-period kick. Also, DUTY=255 gives constant 1 and DUTY=0 gives constant 0 while CTRL bit stays 1.
- FAN_KICKSTART_EN undefined, KICK write 5, CTRL=1 with DUTY0=128 -> addr3 reads 0; fan_out[0] is PWM 50% from the first full period, no kick.

Source files
------------

// File: rtl/fan_pwm_if.sv
// Avalon-MM slave bundle for fan_pwm_controller: register select, write strobe/data and combinational read data.
interface fan_pwm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/fan_pwm_controller.sv
// Two-fan PWM controller: shared free-running timebase, wrap-shadowed duty, per-fan OFF/KICK/RUN FSM.
// Kickstart (KICK state, kick counters, KICK register at addr3) exists only when FAN_KICKSTART_EN is defined.
module fan_pwm_controller #(
  parameter int unsigned PRESCALE     = 50,
  parameter int unsigned KICK_DEFAULT = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  fan_pwm_if.slave   bus,
  output logic [1:0] fan_out
);

`ifdef FAN_KICKSTART_EN
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_KICK = 2'd1, ST_RUN = 2'd2} fan_state_t;
`else
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_RUN = 2'd2} fan_state_t;
`endif

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0]     pre_cnt_r;
  logic [15:0]     pre_cnt_nxt_s;
  logic [7:0]      pwm_cnt_r;
  logic [7:0]      pwm_cnt_nxt_s;
  logic            tick_s;
  logic            wrap_s;
  logic            wr_en_s;
  logic [1:0]      ctrl_r;
  logic [1:0][7:0] duty_stg_r;
  logic [1:0][7:0] duty_act_r;
  logic [1:0][7:0] duty_act_nxt_s;
  fan_state_t      state_r     [2];
  fan_state_t      state_nxt_s [2];
  logic [1:0]      fan_nxt_s;

`ifdef FAN_KICKSTART_EN
  localparam logic [15:0] KICK_RST = 16'(KICK_DEFAULT);
  logic [15:0]      kick_len_r;
  logic [1:0][15:0] kick_cnt_r;
  logic [1:0][15:0] kick_cnt_nxt_s;
  logic [1:0]       in_kick_s;
  logic             unused_wdata_s;
  assign unused_wdata_s = ^bus.writedata[31:16];
`else
  logic             unused_wdata_s;
  assign unused_wdata_s = ^{bus.writedata[31:8], 32'(KICK_DEFAULT)};
`endif

  assign wr_en_s = bus.chipselect && !bus.write_n;

  // Timebase next state: prescaler tick and 8-bit PWM counter; wrap marks the period boundary.
  always_comb begin
    tick_s        = 1'b0;
    wrap_s        = 1'b0;
    pre_cnt_nxt_s = pre_cnt_r;
    pwm_cnt_nxt_s = pwm_cnt_r;
    if (pre_cnt_r == PRE_LAST) begin
      tick_s        = 1'b1;
      wrap_s        = (pwm_cnt_r == 8'hFF);
      pre_cnt_nxt_s = 16'd0;
      pwm_cnt_nxt_s = pwm_cnt_r + 8'd1;
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + 16'd1;
      pwm_cnt_nxt_s = pwm_cnt_r;
    end
  end

  // Timebase registers; free-running, untouched by bus writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= 16'd0;
      pwm_cnt_r <= 8'd0;
    end else begin
      pre_cnt_r <= pre_cnt_nxt_s;
      pwm_cnt_r <= pwm_cnt_nxt_s;
    end
  end

  // Bus-writable registers: enable bits and duty staging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r     <= 2'd0;
      duty_stg_r <= 16'd0;
    end else if (wr_en_s) begin
      case (bus.address)
        2'd0:    ctrl_r        <= bus.writedata[1:0];
        2'd1:    duty_stg_r[0] <= bus.writedata[7:0];
        2'd2:    duty_stg_r[1] <= bus.writedata[7:0];
        default: ctrl_r        <= ctrl_r;
      endcase
    end
  end

`ifdef FAN_KICKSTART_EN
  // Kick length register; a running kick keeps the count it loaded on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kick_len_r <= KICK_RST;
    end else if (wr_en_s && (bus.address == 2'd3)) begin
      kick_len_r <= bus.writedata[15:0];
    end
  end
`endif

  // Active duty only follows staging at the wrap, so a period never changes mid-way.
  always_comb begin
    duty_act_nxt_s = duty_act_r;
    if (wrap_s) begin
      duty_act_nxt_s = duty_stg_r;
    end else begin
      duty_act_nxt_s = duty_act_r;
    end
  end

  // Active duty registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_act_r <= 16'd0;
    end else begin
      duty_act_r <= duty_act_nxt_s;
    end
  end

  // Per-fan next-state logic.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_OFF: begin
          if (ctrl_r[i]) begin
`ifdef FAN_KICKSTART_EN
            state_nxt_s[i] = (kick_len_r != 16'd0) ? ST_KICK : ST_RUN;
`else
            state_nxt_s[i] = ST_RUN;
`endif
          end else begin
            state_nxt_s[i] = ST_OFF;
          end
        end
`ifdef FAN_KICKSTART_EN
        ST_KICK: begin
          if (!ctrl_r[i]) begin
            state_nxt_s[i] = ST_OFF;
          end else if (wrap_s && (kick_cnt_r[i] == 16'd1)) begin
            state_nxt_s[i] = ST_RUN;
          end else begin
            state_nxt_s[i] = ST_KICK;
          end
        end
`endif
        ST_RUN: begin
          if (!ctrl_r[i]) begin
            state_nxt_s[i] = ST_OFF;
          end else begin
            state_nxt_s[i] = ST_RUN;
          end
        end
        default: state_nxt_s[i] = ST_OFF;
      endcase
    end
  end

  // Per-fan state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= ST_OFF;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= state_nxt_s[i];
      end
    end
  end

`ifdef FAN_KICKSTART_EN
  // Kick counter: loaded on entry to KICK, counts down one per wrap while kicking.
  always_comb begin
    kick_cnt_nxt_s = kick_cnt_r;
    for (int i = 0; i < 2; i++) begin
      if ((state_r[i] == ST_OFF) && (state_nxt_s[i] == ST_KICK)) begin
        kick_cnt_nxt_s[i] = kick_len_r;
      end else if ((state_r[i] == ST_KICK) && wrap_s) begin
        kick_cnt_nxt_s[i] = kick_cnt_r[i] - 16'd1;
      end else begin
        kick_cnt_nxt_s[i] = kick_cnt_r[i];
      end
    end
  end

  // Kick counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kick_cnt_r <= 32'd0;
    end else begin
      kick_cnt_r <= kick_cnt_nxt_s;
    end
  end

  assign in_kick_s = {(state_r[1] == ST_KICK), (state_r[0] == ST_KICK)};
`endif

  // Output drive from next state and next compare so fan_out lands with the FSM edge.
  always_comb begin
    fan_nxt_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (state_nxt_s[i])
`ifdef FAN_KICKSTART_EN
        ST_KICK: fan_nxt_s[i] = 1'b1;
`endif
        ST_RUN:  fan_nxt_s[i] = (duty_act_nxt_s[i] == 8'hFF) || (pwm_cnt_nxt_s < duty_act_nxt_s[i]);
        default: fan_nxt_s[i] = 1'b0;
      endcase
    end
  end

  // Registered fan outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fan_out <= 2'b00;
    end else begin
      fan_out <= fan_nxt_s;
    end
  end

  // Zero-latency read mux; unused bits read as zero.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = {30'd0, ctrl_r};
      2'd1:    bus.readdata = {24'd0, duty_stg_r[0]};
      2'd2:    bus.readdata = {24'd0, duty_stg_r[1]};
`ifdef FAN_KICKSTART_EN
      2'd3:    bus.readdata = {14'd0, in_kick_s, kick_len_r};
`endif
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule
